// File: rtl/nesapu_cmd_sched_pkg.sv
// Shared types and constants for the nesapu command scheduler.
// Used by every file of the scheduler through import nesapu_sched_pkg::*.
package nesapu_sched_pkg;

  typedef enum logic {
    CMD_WRITE = 1'b0,
    CMD_WAIT  = 1'b1
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_HI,
    ST_WR_LO,
    ST_WAIT
  } state_e;

  localparam int WAIT_W = 16;
  localparam int CMD_W  = WAIT_W + 1;

  localparam logic [4:0] NESAPU_REG_MAX = 5'h17;
  localparam logic [4:0] LEN_REG_0      = 5'h03;
  localparam logic [4:0] LEN_REG_1      = 5'h07;
  localparam logic [4:0] LEN_REG_2      = 5'h0B;
  localparam logic [4:0] LEN_REG_3      = 5'h0F;

  // Writes to these reload a length counter, so they must always reach the APU.
  function automatic logic is_len_reg(input logic [4:0] r);
    return (r == LEN_REG_0) || (r == LEN_REG_1) || (r == LEN_REG_2) || (r == LEN_REG_3);
  endfunction

endpackage

// File: rtl/nesapu_cmd_sched_if.sv
// Command handshake between the VGM player (master) and the scheduler (slave).
interface nesapu_cmd_sched_if;
  import nesapu_sched_pkg::*;

  logic              in_cmd_valid;
  logic              out_cmd_ready;
  logic              in_cmd_type;
  logic [WAIT_W-1:0] in_cmd_data;

  modport master (output in_cmd_valid, in_cmd_type, in_cmd_data, input out_cmd_ready);
  modport slave  (input in_cmd_valid, in_cmd_type, in_cmd_data, output out_cmd_ready);

endinterface

// File: rtl/nesapu_cmd_sched_fifo.sv
// Single-clock command FIFO with occupancy output; head is readable combinationally.
module nesapu_sched_fifo
  import nesapu_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = CMD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push && (level != (AW+1)'(DEPTH));
  assign pop_ok  = pop && (level != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/nesapu_cmd_sched.sv
// Command scheduler owning nesapu's register-write port: FIFO, write-pulse shaper, tick waits.
// Optional write deduplication against a shadow register file: define NESAPU_SCHED_DEDUP_EN.
module nesapu_cmd_sched
  import nesapu_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WR_HI = 2,
  parameter int WR_LO = 2
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  nesapu_cmd_sched_if.slave        cmd,
  input  logic                     in_tick,
  output logic [4:0]               out_reg,
  output logic [7:0]               out_val,
  output logic                     out_wr,
  output logic                     out_busy,
  output logic [$clog2(DEPTH):0]   out_level
);

  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int PH_MAX = (WR_HI > WR_LO) ? WR_HI : WR_LO;
  localparam int PW     = $clog2(PH_MAX + 1);

  state_e            state;
  logic [PW-1:0]     phase;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CMD_W-1:0]  head;
  logic [LW-1:0]     level;
  logic              push;
  logic              pop;
  cmd_type_e         head_type;
  logic [4:0]        head_reg;
  logic [7:0]        head_val;
  logic              in_range;
  logic              dup;
  logic              issue;

  assign cmd.out_cmd_ready = ~in_rst && (level != LW'(DEPTH));
  assign push      = cmd.in_cmd_valid && cmd.out_cmd_ready;
  assign pop       = (state == ST_IDLE) && (level != '0);
  assign head_type = cmd_type_e'(head[WAIT_W]);
  assign head_reg  = head[12:8];
  assign head_val  = head[7:0];
  assign in_range  = (head_reg <= NESAPU_REG_MAX);
  assign issue     = pop && (head_type == CMD_WRITE) && in_range && !dup;
  assign out_level = level;
  assign out_busy  = (state != ST_IDLE) || (level != '0);

  nesapu_sched_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (in_clk),
    .rst   (in_rst),
    .push  (push),
    .din   ({cmd.in_cmd_type, cmd.in_cmd_data}),
    .pop   (pop),
    .dout  (head),
    .level (level)
  );

`ifdef NESAPU_SCHED_DEDUP_EN
  localparam int SHADOW_N = 24;

  logic [7:0]          shadow [SHADOW_N];
  logic [SHADOW_N-1:0] shadow_vld;

  assign dup = in_range && shadow_vld[head_reg] && (shadow[head_reg] == head_val)
               && !is_len_reg(head_reg);

  always_ff @(posedge in_clk) begin
    if (issue) shadow[head_reg] <= head_val;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst)     shadow_vld <= '0;
    else if (issue) shadow_vld[head_reg] <= 1'b1;
  end
`else
  assign dup = 1'b0;
`endif

  // The popped head is decoded in the pop cycle so out_wr rises the very next cycle.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= ST_IDLE;
      phase    <= '0;
      wait_cnt <= '0;
      out_wr   <= 1'b0;
      out_reg  <= '0;
      out_val  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            out_reg <= head_reg;
            out_val <= head_val;
            out_wr  <= 1'b1;
            phase   <= '0;
            state   <= ST_WR_HI;
          end else if (pop && (head_type == CMD_WAIT) && (head[WAIT_W-1:0] != '0)) begin
            wait_cnt <= head[WAIT_W-1:0];
            state    <= ST_WAIT;
          end
        end
        ST_WR_HI: begin
          if (phase == PW'(WR_HI - 1)) begin
            phase  <= '0;
            out_wr <= 1'b0;
            state  <= ST_WR_LO;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_WR_LO: begin
          if (phase == PW'(WR_LO - 1)) begin
            phase <= '0;
            state <= ST_IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0)  state    <= ST_IDLE;
          else if (in_tick)    wait_cnt <= wait_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
